noc_out_port_arbiter: RTL and testbench
=======================================

# noc_out_port_arbiter

Clocked round-robin arbiter that shares one router output port among up to N_REQ packet sources: the local core and the four neighbour ports, i.e. the path-computation outputs of the other input ports. Each source presents 11-bit packets `{data[6:0], addr[3:0]}` on a valid/ready channel. The block grants one source at a time, captures the winning packet into a single output holding register, and presents it downstream on a valid/ready channel. It sits between the path-computation stage and the link driver of each output port.

## Interface
- N_REQ, 5: number of requesters; index 0 is the local core, 1..4 are neighbour ports 1..4.
- WIDTH, 11: packet width in bits.
- IDW, $clog2(N_REQ): width of grant_id.

- clk  in  1  Block clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- req_valid  in  N_REQ  Per-requester packet valid.
- req_data  in  N_REQ*WIDTH  Packed packets; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  Per-requester accept; at most one bit high per cycle.
- out_valid  out  1  Holding register occupied.
- out_data  out  WIDTH  Holding register contents.
- out_ready  in  1  Downstream accept.
- grant_id  out  IDW  Index of the requester whose packet is in the holding register.

## Operation
- Holding register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Arbitration is enabled in a cycle when the state is EMPTY, or FULL with out_ready=1 (drain and refill in the same cycle).
- Winner: the first i with req_valid[i]=1, searching from ptr upward modulo N_REQ.
- req_ready[winner]=1 combinationally in an arbitration-enabled cycle. All other req_ready bits are 0. All req_ready bits are 0 when arbitration is disabled, when no request is present, or while rst_n=0.
- Transfer on a clock edge where req_valid[w] & req_ready[w]:
  - out_data ← packet w; grant_id ← w; state → FULL; ptr ← (w+1) mod N_REQ.
- Drain with no new winner (out_valid & out_ready, no request): state → EMPTY. out_data and grant_id hold their last values.
- FULL with out_ready=0: out_data and grant_id are held stable; no req_ready is asserted.
- ptr changes only on a transfer.
- Packet contents pass through unmodified; the arbiter never inspects addr.
- Requesters keep req_valid and req_data stable until accepted. The arbiter does not rely on this for correctness.
- Reset values: out_valid=0, out_data=0, grant_id=0, ptr=0, state EMPTY.
- Reset asserted mid-operation: the held packet is discarded, and req_ready drops to 0 immediately (asynchronously).
- N_REQ=1 is legal: ptr stays 0.

## Timing
- Latency: packet accepted at edge k appears on out_data with out_valid=1 after edge k (one cycle).
- Throughput: one packet per cycle while out_ready=1 and requests are present.
- req_ready depends combinationally on req_valid, out_valid, out_ready and rst_n. It has no combinational path from req_data.
- out_valid, out_data and grant_id are registered outputs, with no combinational path from inputs.
- Fairness: a continuously valid requester is granted within N_REQ transfers.

## Configuration
- CORE_PRIO_EN defined:
  - Requester 0 (core) has strict priority. If req_valid[0]=1 in an arbitration-enabled cycle, 0 wins and ptr is unchanged.
  - Otherwise round-robin runs over requesters 1..N_REQ-1 from ptr, skipping 0.
  - Fairness among 1..N_REQ-1 is retained; the core can starve the neighbours.
- CORE_PRIO_EN undefined: plain round-robin over all N_REQ requesters as described above.

## Test plan
- Reset, then req_valid=5'b00100 with packet 11'b1111000_0100, out_ready=1 → req_ready=5'b00100. Next cycle: out_valid=1, out_data=11'b1111000_0100, grant_id=2; then out_valid=0.
- All five requesters valid continuously from reset, out_ready=1 → grant_id sequence 0,1,2,3,4,0 on consecutive cycles, out_valid held at 1.
- FULL with out_ready=0 for 4 cycles, all requesters valid → out_data and grant_id unchanged, req_ready=0. On out_ready=1, the next requester is accepted in that cycle.
- Packet held (grant_id=3), rst_n pulsed low mid-cycle → out_valid=0 and req_ready=0 immediately. After release the first grant goes to the lowest valid index (ptr=0).
- Requesters 1 and 3 valid, ptr=2 → 3 granted first, then 1, then 3 (wrap-around).
- CORE_PRIO_EN defined, requesters 0 and 2 continuously valid → grant_id stays 0 while req_valid[0]=1. Drop req_valid[0] → 2 granted next cycle.

Source files
------------

// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: round-robin arbiter sharing one router output port among N_REQ packet sources.
// Optional macro CORE_PRIO_EN gives requester 0 (local core) strict priority over the neighbour ports.
module noc_out_port_arbiter #(
  parameter int N_REQ = 5,
  parameter int WIDTH = 11,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [IDW-1:0]         grant_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [IDW-1:0]   id_r;

  logic             arb_en_s;
  logic             found_s;
  logic             xfer_s;
  logic [IDW-1:0]   win_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [N_REQ-1:0] cand_s;

  function automatic int rr_idx(input logic [IDW-1:0] base, input int offset);
    return (int'(base) + offset) % N_REQ;
  endfunction

  assign arb_en_s = (state_r == EMPTY) || out_ready;
  assign xfer_s   = arb_en_s && found_s;

  // Candidates for the rotating search; under core priority requester 0 is handled separately.
  always_comb begin
    cand_s = req_valid;
`ifdef CORE_PRIO_EN
    cand_s[0] = 1'b0;
`endif
  end

  // Rotating search from ptr: scanning offsets downward lets the nearest hit win.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_s[rr_idx(ptr_r, k)]) begin
        found_s = 1'b1;
        win_s   = IDW'(rr_idx(ptr_r, k));
      end else begin
        found_s = found_s;
      end
    end
`ifdef CORE_PRIO_EN
    if (req_valid[0]) begin
      found_s = 1'b1;
      win_s   = '0;
    end else begin
      found_s = found_s;
    end
`endif
  end

  // Pointer advances past the winner; a strict-priority core grant leaves it untouched.
  always_comb begin
    ptr_next_s = IDW'((int'(win_s) + 1) % N_REQ);
`ifdef CORE_PRIO_EN
    if (win_s == '0) begin
      ptr_next_s = ptr_r;
    end else begin
      ptr_next_s = IDW'((int'(win_s) + 1) % N_REQ);
    end
`endif
  end

  // One-hot accept for the winner, forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && xfer_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Holding register state, contents and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= '0;
      data_r  <= '0;
      id_r    <= '0;
    end else if (xfer_s) begin
      state_r <= FULL;
      data_r  <= req_data[int'(win_s)*WIDTH +: WIDTH];
      id_r    <= win_s;
      ptr_r   <= ptr_next_s;
    end else if ((state_r == FULL) && out_ready) begin
      state_r <= EMPTY;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign grant_id  = id_r;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Self-checking bench for noc_out_port_arbiter: reference-model scoreboard plus directed scenarios.
module tb_noc_out_port_arbiter;

  localparam int N_REQ = 5;
  localparam int WIDTH = 11;
  localparam int IDW   = 3;
`ifdef CORE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready = 1'b0;
  logic [IDW-1:0]         grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t             sb_q[$];
  logic             m_valid = 1'b0;
  int               m_ptr   = 0;
  int               m_id    = 0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [WIDTH-1:0] pk [N_REQ];

  noc_out_port_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int model_win(input logic [N_REQ-1:0] v, input int p);
    int r;
    r = -1;
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r < 0 && v[(p + k) % N_REQ] && !(PRIO && ((p + k) % N_REQ) == 0)) r = (p + k) % N_REQ;
    end
    return r;
  endfunction

  // Scoreboard: predict at negedge, commit at posedge, pop and compare at the following negedge.
  always begin : scoreboard
    int               w;
    logic [N_REQ-1:0] er;
    logic [WIDTH-1:0] wd;
    exp_t             e;
    @(negedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_ptr = 0; m_id = 0; m_data = '0;
      sb_q.delete();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 11'd0 || grant_id !== 3'd0 || req_ready !== 5'd0) begin
        n_fail++;
        $display("FAIL sb_reset: valid=%b data=%h id=%0d ready=%b, required 0/0/0/0", out_valid, out_data, grant_id, req_ready);
      end
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        m_id = e.id;
        m_data = e.data;
      end
      n_checks++;
      if (out_valid !== m_valid || grant_id !== IDW'(m_id) || out_data !== m_data) begin
        n_fail++;
        $display("FAIL sb_out: valid=%b id=%0d data=%h, required valid=%b id=%0d data=%h", out_valid, grant_id, out_data, m_valid, m_id, m_data);
      end
      w = -1;
      if (!m_valid || out_ready) w = model_win(req_valid, m_ptr);
      er = '0;
      wd = '0;
      if (w >= 0) begin
        er[w] = 1'b1;
        wd = req_data[w*WIDTH +: WIDTH];
      end
      n_checks++;
      if (req_ready !== er) begin
        n_fail++;
        $display("FAIL sb_ready: req_ready=%b, required %b", req_ready, er);
      end
      @(posedge clk);
      if (rst_n) begin
        if (w >= 0) begin
          sb_q.push_back('{w, wd});
          m_valid = 1'b1;
          if (!(PRIO && w == 0)) m_ptr = (w + 1) % N_REQ;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pkts();
    for (int i = 0; i < N_REQ; i++) begin
      pk[i] = {7'(i * 17 + 3), 4'(i + 6)};
      req_data[i*WIDTH +: WIDTH] = pk[i];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    req_valid = 5'b11111;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (req_ready !== 5'b00000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b valid=%b, required 00000/0", req_ready, out_valid);
    end
    tick(2);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick(1);
    req_data = {$urandom, $urandom};
    req_data[2*WIDTH +: WIDTH] = 11'b1111000_0100;
    req_valid = 5'b00100;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 5'b00100) begin
      n_fail++;
      $display("FAIL single_ready: req_ready=%b, required 00100", req_ready);
    end
    tick(1);
    req_valid = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 11'b1111000_0100 || grant_id !== 3'd2) begin
      n_fail++;
      $display("FAIL single_out: valid=%b data=%b id=%0d, required 1/11110000100/2", out_valid, out_data, grant_id);
    end
    tick(1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ids[6] = '{0, 1, 2, 3, 4, 0};
    set_pkts();
    req_valid = 5'b11111;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_checks++;
      if (out_valid !== 1'b1 || grant_id !== IDW'(exp_ids[i]) || out_data !== pk[exp_ids[i]]) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%b id=%0d data=%h, required 1/%0d/%h", i, out_valid, grant_id, out_data, exp_ids[i], pk[exp_ids[i]]);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 5'b00000) begin
        n_fail++;
        $display("FAIL stall_ready_%0d: req_ready=%b, required 00000", i, req_ready);
      end
      tick(1);
      n_checks++;
      if (grant_id !== 3'd0 || out_data !== pk[0] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: id=%0d data=%h valid=%b, required 0/%h/1", i, grant_id, out_data, out_valid, pk[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 5'b00010) begin
      n_fail++;
      $display("FAIL stall_release: req_ready=%b, required 00010", req_ready);
    end
    tick(1);
    n_checks++;
    if (grant_id !== 3'd1 || out_data !== pk[1]) begin
      n_fail++;
      $display("FAIL stall_next: id=%0d data=%h, required 1/%h", grant_id, out_data, pk[1]);
    end
  endtask

  task automatic test_wrap();
    int exp_ids[3] = '{3, 1, 3};
    req_valid = 5'b01010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (grant_id !== IDW'(exp_ids[i]) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_%0d: id=%0d valid=%b, required %0d/1", i, grant_id, out_valid, exp_ids[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_pkts();
    req_valid = 5'b01000;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    req_valid = 5'b11111;
    tick(1);
    n_checks++;
    if (grant_id !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_held: id=%0d valid=%b, required 3/1", grant_id, out_valid);
    end
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || req_ready !== 5'b00000) begin
      n_fail++;
      $display("FAIL rmid_async: valid=%b ready=%b, required 0/00000", out_valid, req_ready);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (grant_id !== 3'd0 || out_valid !== 1'b1 || out_data !== pk[0]) begin
      n_fail++;
      $display("FAIL rmid_first: id=%0d valid=%b data=%h, required 0/1/%h", grant_id, out_valid, out_data, pk[0]);
    end
  endtask

  task automatic test_core_prio();
    set_pkts();
    req_valid = 5'b00101;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (grant_id !== 3'd0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL prio_core_%0d: id=%0d valid=%b, required 0/1", i, grant_id, out_valid);
      end
    end
    req_valid = 5'b00100;
    tick(1);
    n_checks++;
    if (grant_id !== 3'd2 || out_data !== pk[2]) begin
      n_fail++;
      $display("FAIL prio_drop: id=%0d data=%h, required 2/%h", grant_id, out_data, pk[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = N_REQ'($urandom);
      req_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef CORE_PRIO_EN
    test_core_prio();
`else
    test_back_to_back();
    test_stall();
    test_wrap();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
